// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl
//   Sequencer that drives the core's 35-bit instruction bus through the full
//   convolution schedule: per kernel position (kij) it loads weights into L0,
//   loads the PEs, streams activations, executes and drains the OFIFO into
//   psum memory. It then runs the accumulation pass over every output pixel,
//   using an external address table for the psum addresses.
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-high
//   start       begin a schedule (only looked at while idle)
//   acc_addr    address-table data for acc_idx (combinational, same cycle)
//   inst        registered core instruction
//   core_reset  registered reset to the core
//   acc_idx     address-table index
//   out_valid   one-cycle pulse: core output for the current onij is valid
//   busy        schedule in progress
//   done        one-cycle completion pulse
//
// Every output is computed from the *next* state/counters and registered, so
// the fields belonging to a state are on the outputs for every cycle the FSM
// sits in that state, and cycle c of a state lines up with counter value c.
module core_seq_ctrl #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int len_nij  = 36,
  parameter int len_kij  = 9,
  parameter int len_onij = 16,
  parameter int w_base   = 1024,
  parameter int gap      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] acc_addr,
  output logic [34:0] inst,
  output logic        core_reset,
  output logic [7:0]  acc_idx,
  output logic        out_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_CRST, S_WL0, S_GAP_W, S_WLOAD, S_GAP_L, S_AL0, S_GAP_A,
    S_EXEC, S_DRAIN, S_OFRD, S_ACC, S_DONE
  } state_t;

  typedef struct packed {
    logic        msb;
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;

  // Both memories disabled (CEN/WEN high), everything else low.
  localparam inst_t      INST_IDLE = 35'h1_800C_0000;
  localparam int         ACC_LEN   = 12;
  localparam logic [7:0] KIJ_LAST  = 8'(len_kij - 1);
  localparam logic [7:0] ONIJ_LAST = 8'(len_onij - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n, last_c;
  logic [7:0]  kij, kij_n;
  logic [7:0]  onij, onij_n;

  inst_t       ins_n;
  logic        crst_n, ov_n, busy_n, done_n;
  logic [7:0]  idx_n;

  // Last counter value of the current state.
  always_comb begin
    last_c = '0;
    case (state)
      S_CRST:                    last_c = 16'd1;
      S_WL0:                     last_c = 16'(col);
      S_GAP_W, S_GAP_L, S_GAP_A: last_c = 16'(gap - 1);
      S_WLOAD:                   last_c = 16'(col - 1);
      S_AL0:                     last_c = 16'(len_nij);
      S_EXEC:                    last_c = 16'(len_nij - 1);
      S_DRAIN:                   last_c = 16'(row + col - 1);
      S_OFRD:                    last_c = 16'(len_nij);
      S_ACC:                     last_c = 16'(ACC_LEN - 1);
      default:                   last_c = '0;
    endcase
  end

  // Next state and counters.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    kij_n   = kij;
    onij_n  = onij;
    if (state == S_IDLE) begin
      cnt_n = '0;
      if (start) begin
        state_n = S_CRST;
        kij_n   = '0;
        onij_n  = '0;
      end
    end else if (state == S_DONE) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else if (cnt == last_c) begin
      cnt_n = '0;
      case (state)
        S_CRST:  state_n = S_WL0;
        S_WL0:   state_n = S_GAP_W;
        S_GAP_W: state_n = S_WLOAD;
        S_WLOAD: state_n = S_GAP_L;
        S_GAP_L: state_n = S_AL0;
        S_AL0:   state_n = S_GAP_A;
        S_GAP_A: state_n = S_EXEC;
        S_EXEC:  state_n = S_DRAIN;
        S_DRAIN: state_n = S_OFRD;
        S_OFRD: begin
          if (kij < KIJ_LAST) begin
            kij_n   = kij + 8'd1;
            state_n = S_CRST;
          end else begin
            onij_n  = '0;
            state_n = S_ACC;
          end
        end
        S_ACC: begin
          if (onij < ONIJ_LAST) onij_n  = onij + 8'd1;
          else                  state_n = S_DONE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Output decode of the upcoming cycle.
  always_comb begin
    ins_n  = INST_IDLE;
    crst_n = 1'b0;
    idx_n  = '0;
    ov_n   = 1'b0;
    busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n = (state_n == S_DONE);
    case (state_n)
      S_CRST: crst_n = 1'b1;
      S_WL0: begin
        // xmem read on c0..col-1, L0 write trails it by one cycle.
        if (cnt_n < 16'(col)) begin
          ins_n.cen_xmem = 1'b0;
          ins_n.a_xmem   = 11'(w_base + kij_n * col + cnt_n);
        end
        if (cnt_n != '0) ins_n.l0_wr = 1'b1;
      end
      S_WLOAD: begin
        ins_n.l0_rd = 1'b1;
        ins_n.load  = 1'b1;
      end
      S_AL0: begin
        if (cnt_n < 16'(len_nij)) begin
          ins_n.cen_xmem = 1'b0;
          ins_n.a_xmem   = 11'(cnt_n);
        end
        if (cnt_n != '0) ins_n.l0_wr = 1'b1;
      end
      S_EXEC: begin
        ins_n.l0_rd   = 1'b1;
        ins_n.execute = 1'b1;
      end
      S_OFRD: begin
        // OFIFO pop on c0..len_nij-1; the popped word is written to pmem
        // one cycle later.
        if (cnt_n < 16'(len_nij)) ins_n.ofifo_rd = 1'b1;
        if (cnt_n != '0) begin
          ins_n.cen_pmem = 1'b0;
          ins_n.wen_pmem = 1'b0;
          ins_n.a_pmem   = 11'(kij_n * len_nij + cnt_n - 16'd1);
        end
      end
      S_ACC: begin
        if (cnt_n == 16'd0) crst_n = 1'b1;
        if (cnt_n >= 16'd1 && cnt_n <= 16'd9) begin
          ins_n.cen_pmem = 1'b0;
          idx_n          = 8'(onij_n * len_kij + cnt_n - 16'd1);
        end
        // Table data is captured at the edge after acc_idx is shown, so the
        // pmem address trails acc_idx by a cycle; keep capturing through c10
        // so the last table entry lands together with the final acc.
        if (cnt_n >= 16'd1 && cnt_n <= 16'd10) ins_n.a_pmem = acc_addr;
        // pmem read data arrives one cycle after the read.
        if (cnt_n >= 16'd2 && cnt_n <= 16'd10) ins_n.acc = 1'b1;
        if (cnt_n == 16'(ACC_LEN - 1)) ov_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      kij        <= '0;
      onij       <= '0;
      inst       <= INST_IDLE;
      core_reset <= 1'b0;
      acc_idx    <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      kij        <= kij_n;
      onij       <= onij_n;
      inst       <= ins_n;
      core_reset <= crst_n;
      acc_idx    <= idx_n;
      out_valid  <= ov_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Testbench for core_seq_ctrl. The stimulus side pushes the expected output
// record of every cycle into a queue (the whole schedule is pushed at start,
// built from the phase list with plain loops); a negedge monitor pops one
// record per cycle and compares. Address table, start re-pulse point and
// reset point are randomized.
module tb_core_seq_ctrl;

  localparam int ROW = 8, COL = 8, NIJ = 36, KIJ = 9, ONIJ = 16, WB = 1024, GAP = 4;
  localparam logic [34:0] IDLE_I = 35'h1_800C_0000;
  localparam int RUN_LEN = 1606;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [10:0] acc_addr;
  logic [34:0] inst;
  logic        core_reset, out_valid, busy, done;
  logic [7:0]  acc_idx;

  int unsigned amul, aoff;
  int          errors = 0;
  int          checks = 0;

  typedef struct packed {
    logic [46:0] val;
    logic [46:0] dc;
  } exp_t;
  exp_t q[$];

  core_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .acc_addr(acc_addr),
    .inst(inst), .core_reset(core_reset), .acc_idx(acc_idx),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External address table.
  assign acc_addr = 11'(acc_idx * amul + aoff);

  function automatic logic [10:0] tbl(input int idx);
    return 11'(idx * amul + aoff);
  endfunction

  task automatic push(input logic [34:0] i, input logic cr, input logic [7:0] ix,
                      input logic ov, input logic bz, input logic dn, input logic [46:0] dc);
    exp_t e;
    e.val = {i, cr, ix, ov, bz, dn};
    e.dc  = dc;
    q.push_back(e);
  endtask

  task automatic push_idle();
    push(IDLE_I, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Whole schedule, one record per cycle, from the first CRST cycle to DONE.
  task automatic push_run();
    logic [34:0] i;
    logic [7:0]  ix;
    logic [46:0] dc;
    for (int k = 0; k < KIJ; k++) begin
      repeat (2) push(IDLE_I, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, '0);
      for (int c = 0; c <= COL; c++) begin
        i = IDLE_I;
        if (c < COL) begin i[19] = 1'b0; i[17:7] = 11'(WB + k * COL + c); end
        if (c >= 1) i[2] = 1'b1;
        push(i, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, '0);
      end
      repeat (GAP) push(IDLE_I, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, '0);
      for (int c = 0; c < COL; c++) begin
        i = IDLE_I; i[3] = 1'b1; i[0] = 1'b1;
        push(i, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, '0);
      end
      repeat (GAP) push(IDLE_I, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, '0);
      for (int c = 0; c <= NIJ; c++) begin
        i = IDLE_I;
        if (c < NIJ) begin i[19] = 1'b0; i[17:7] = 11'(c); end
        if (c >= 1) i[2] = 1'b1;
        push(i, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, '0);
      end
      repeat (GAP) push(IDLE_I, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, '0);
      for (int c = 0; c < NIJ; c++) begin
        i = IDLE_I; i[3] = 1'b1; i[1] = 1'b1;
        push(i, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, '0);
      end
      repeat (ROW + COL) push(IDLE_I, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, '0);
      for (int c = 0; c <= NIJ; c++) begin
        i = IDLE_I;
        if (c < NIJ) i[6] = 1'b1;
        if (c >= 1) begin i[32] = 1'b0; i[31] = 1'b0; i[30:20] = 11'(k * NIJ + c - 1); end
        push(i, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, '0);
      end
    end
    for (int o = 0; o < ONIJ; o++) begin
      for (int c = 0; c < 12; c++) begin
        i  = IDLE_I;
        ix = 8'd0;
        dc = '0;
        if (c >= 1 && c <= 9) begin i[32] = 1'b0; ix = 8'(o * KIJ + c - 1); end
        if (c >= 2 && c <= 10) begin i[33] = 1'b1; i[30:20] = tbl(o * KIJ + c - 2); end
        if (c == 1) dc[42:32] = 11'h7FF;  // address not yet from this window
        push(i, c == 0, ix, c == 11, 1'b1, 1'b0, dc);
      end
    end
    push(IDLE_I, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  // Monitor: one record per cycle while anything is expected.
  always @(negedge clk) begin
    exp_t        e;
    logic [46:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {inst, core_reset, acc_idx, out_valid, busy, done};
      checks++;
      if (((act ^ e.val) & ~e.dc) !== 47'd0) begin
        errors++;
        $display("FAIL trace t=%0t got inst=%h crst=%b idx=%0d ov=%b busy=%b done=%b want inst=%h crst=%b idx=%0d ov=%b busy=%b done=%b",
                 $time, act[46:12], act[11], act[10:3], act[2], act[1], act[0],
                 e.val[46:12], e.val[11], e.val[10:3], e.val[2], e.val[1], e.val[0]);
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      push_idle();
    end
  endtask

  // Runs one schedule. rep_cyc: cycle (1 = first CRST) in which start is
  // pulsed again; rst_cyc: cycle in which reset is raised. 0 disables.
  task automatic run(input int rep_cyc, input int rst_cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_run();
    for (int cyc = 1; cyc <= RUN_LEN; cyc++) begin
      if (cyc == rst_cyc) begin
        reset = 1'b1;
        while (q.size() > 1) void'(q.pop_back());
        @(posedge clk); #1;
        reset = 1'b0;
        push_idle();
        return;
      end
      start = (cyc == rep_cyc);
      if (cyc < RUN_LEN) begin @(posedge clk); #1; end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    amul  = 1;
    aoff  = 100;
    // Reset held for 3 edges with start pulsed during it.
    @(posedge clk); #1;
    push_idle();
    start = 1'b1;
    repeat (2) begin @(posedge clk); #1; push_idle(); end
    start = 1'b0;
    reset = 1'b0;
    idle_cycles($urandom_range(1, 5));

    // Run 1: table = idx+100, start re-pulsed during some EXEC.
    run(69 + 157 * $urandom_range(0, 8) + $urandom_range(0, 35), 0);
    idle_cycles($urandom_range(1, 5));

    // Run 2: random table, reset during OFRD of kij=4.
    amul = $urandom_range(1, 3);
    aoff = $urandom_range(0, 1500);
    run(0, 749 + $urandom_range(0, 36));
    idle_cycles($urandom_range(1, 5));

    // Run 3: random table, full completion after the aborted run.
    amul = $urandom_range(1, 3);
    aoff = $urandom_range(0, 1500);
    run(0, 0);
    idle_cycles(3);

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d records left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
